// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer helpers (depth derivation, Gray conversion)
package fifo_pkg;

  // Widest pointer the helper functions handle; callers zero-extend and truncate.
  localparam int PTR_MAX_W = 32;

  // Number of memory entries addressed by addr_width address bits.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [PTR_MAX_W-1:0] bin_to_gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code back to binary: each bit is the XOR of itself and all higher bits.
  function automatic logic [PTR_MAX_W-1:0] gray_to_bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter of parametrised width
module gray2bin #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Bit i of the binary value is the parity of Gray bits W-1 down to i.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/rd_ptr_empty_ctrl.sv
// rtl/rd_ptr_empty_ctrl.sv - async FIFO read-side pointer, empty/almost-empty, level and underflow
module rd_ptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int Addr_width = 5,
  parameter int AE_level   = 4
) (
  input  logic                  Rd_clk,
  input  logic                  rst,
  input  logic                  Rd_en,
  input  logic [Addr_width:0]   Synch_Wr_point,
  output logic [Addr_width-1:0] Rd_addr,
  output logic [Addr_width:0]   Rd_point,
  output logic                  Empty_sig,
  output logic                  Almost_empty,
  output logic [Addr_width:0]   Rd_level,
  output logic                  Rd_valid,
  output logic                  Underflow
);

  localparam int PW       = Addr_width + 1;
  localparam int DEPTH    = fifo_depth(Addr_width);
  // Out-of-range thresholds are clamped so the flag still means "nearly drained".
  localparam int AE_CLAMP = (AE_level < DEPTH) ? AE_level : DEPTH - 1;
  localparam logic [PW-1:0] AE_THR = PW'(AE_CLAMP);

  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_nx;
  logic [PW-1:0] rd_gray_nx;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] lvl_nx;
  logic          rd_acc;

  gray2bin #(.W(PW)) u_wr_g2b (
    .gray (Synch_Wr_point),
    .bin  (wr_bin)
  );

  // Reads are accepted against the registered flag only, so the accept path is short.
  assign rd_acc     = Rd_en & ~Empty_sig;
  assign rd_bin_nx  = rd_bin + PW'(rd_acc);
  assign rd_gray_nx = PW'(bin_to_gray(PTR_MAX_W'(rd_bin_nx)));
  assign lvl_nx     = wr_bin - rd_bin_nx;
  assign Rd_addr    = rd_bin[Addr_width-1:0];

  // Pointer, flag and level registers; reset wins over any read in flight.
  always_ff @(posedge Rd_clk) begin
    if (!rst) begin
      rd_bin       <= '0;
      Rd_point     <= '0;
      Empty_sig    <= 1'b1;
      Almost_empty <= 1'b1;
      Rd_level     <= '0;
      Rd_valid     <= 1'b0;
      Underflow    <= 1'b0;
    end else begin
      rd_bin       <= rd_bin_nx;
      Rd_point     <= rd_gray_nx;
      // Full-width compare keeps the wrap bit, so a full FIFO never reads as empty.
      Empty_sig    <= (rd_gray_nx == Synch_Wr_point);
      Almost_empty <= (lvl_nx <= AE_THR);
      Rd_level     <= lvl_nx;
      Rd_valid     <= rd_acc;
      Underflow    <= Underflow | (Rd_en & Empty_sig);
    end
  end

endmodule
